// File: rtl/lvds_dpa_link_ctrl.sv
// ============================================================================
//  Module      : lvds_dpa_link_ctrl
//  Description : Link bring-up sequencer for one LVDS 7:1 receive lane pair
//                with dynamic phase alignment. Pulses DPA restart, waits for
//                lane DPA done, lets the lane settle, qualifies it over an
//                error-count window and either reports the link good or
//                retrains up to a retry limit.
//  Options     : define LVDS_LOCKED_MONITOR_EN to keep running qualification
//                windows while LOCKED and retrain on a failing window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvds_dpa_link_ctrl #(
    parameter int DPA_RST_CYC = 16,
    parameter int DPA_TIMEOUT = 65535,
    parameter int SETTLE_CYC  = 64,
    parameter int WIN_CYC     = 4096,
    parameter int ERR_THRESH  = 0,
    parameter int MAX_RETRY   = 8
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_enable,
    input  logic        I_lane_dpa_done,
    input  logic        I_error_flag,
    output logic        O_dpa_rst,
    output logic        O_link_ok,
    output logic        O_link_fail,
    output logic [2:0]  O_state,
    output logic [7:0]  O_retry_cnt,
    output logic [15:0] O_win_err_cnt
);

    // State encoding
    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_DPA_RST  = 3'd1;
    localparam logic [2:0] c_S_DPA_WAIT = 3'd2;
    localparam logic [2:0] c_S_SETTLE   = 3'd3;
    localparam logic [2:0] c_S_MONITOR  = 3'd4;
    localparam logic [2:0] c_S_LOCKED   = 3'd5;
    localparam logic [2:0] c_S_FAIL     = 3'd6;

    // One shared phase counter serves every timed state; size it for the longest
    localparam int c_MAX_A   = (DPA_RST_CYC > DPA_TIMEOUT) ? DPA_RST_CYC : DPA_TIMEOUT;
    localparam int c_MAX_B   = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int c_CNT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(DPA_RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(DPA_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_SET_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WIN_LAST = c_CNT_W'(WIN_CYC - 1);

    localparam logic [15:0] c_ERR_THRESH = 16'(ERR_THRESH);
    localparam logic [7:0]  c_MAX_RETRY  = 8'(MAX_RETRY);

`ifdef LVDS_LOCKED_MONITOR_EN
    localparam logic c_LOCKED_MON = 1'b1;
`else
    localparam logic c_LOCKED_MON = 1'b0;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [15:0]        r_err;
    logic [15:0]        w_err_next;
    logic               w_in_win;
    logic               w_win_last;
    logic               w_win_pass;
    logic               w_fail_evt;
    logic               w_cnt_run;
    logic [7:0]         w_retry_inc;

    logic               r_dpa_rst;
    logic               r_link_ok;
    logic               r_link_fail;
    logic [7:0]         r_retry;
    logic [15:0]        r_win_err;

    logic               w_dpa_rst_d;
    logic               w_link_ok_d;
    logic               w_link_fail_d;
    logic [7:0]         w_retry_d;
    logic [15:0]        w_win_err_d;

    // Window bookkeeping and saturating increments shared by the FSM and outputs
    always_comb begin
        w_in_win    = (r_state == c_S_MONITOR) ||
                      (c_LOCKED_MON && (r_state == c_S_LOCKED));
        w_win_last  = w_in_win && (r_cnt == c_WIN_LAST);
        w_err_next  = (I_error_flag && (r_err != 16'hFFFF)) ? (r_err + 16'd1) : r_err;
        w_win_pass  = (w_err_next <= c_ERR_THRESH);
        w_retry_inc = (r_retry == 8'hFF) ? 8'hFF : (r_retry + 8'd1);
        w_cnt_run   = (r_state == c_S_DPA_RST)  || (r_state == c_S_DPA_WAIT) ||
                      (r_state == c_S_SETTLE)   || w_in_win;
    end

    // State register
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; an attempt failure is resolved against the retry budget last
    always_comb begin
        w_next_state = r_state;
        w_fail_evt   = 1'b0;
        if (!I_enable) begin
            w_next_state = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    w_next_state = c_S_DPA_RST;
                end
                c_S_DPA_RST: begin
                    if (r_cnt == c_RST_LAST) begin
                        w_next_state = c_S_DPA_WAIT;
                    end
                end
                c_S_DPA_WAIT: begin
                    // Lock arriving on the timeout cycle still counts as lock
                    if (I_lane_dpa_done) begin
                        w_next_state = c_S_SETTLE;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_fail_evt = 1'b1;
                    end
                end
                c_S_SETTLE: begin
                    if (!I_lane_dpa_done) begin
                        w_fail_evt = 1'b1;
                    end else if (r_cnt == c_SET_LAST) begin
                        w_next_state = c_S_MONITOR;
                    end
                end
                c_S_MONITOR: begin
                    if (!I_lane_dpa_done) begin
                        w_fail_evt = 1'b1;
                    end else if (w_win_last) begin
                        if (w_win_pass) begin
                            w_next_state = c_S_LOCKED;
                        end else begin
                            w_fail_evt = 1'b1;
                        end
                    end
                end
                c_S_LOCKED: begin
                    // Loss of lock retrains without charging the retry budget
                    if (!I_lane_dpa_done) begin
                        w_next_state = c_S_DPA_RST;
                    end else if (w_win_last && !w_win_pass) begin
                        w_fail_evt = 1'b1;
                    end
                end
                c_S_FAIL: begin
                    w_next_state = c_S_FAIL;
                end
                default: begin
                    w_next_state = c_S_IDLE;
                end
            endcase
            if (w_fail_evt) begin
                w_next_state = (w_retry_inc >= c_MAX_RETRY) ? c_S_FAIL : c_S_DPA_RST;
            end
        end
    end

    // Output decode from the upcoming state so registered outputs align with it
    always_comb begin
        w_dpa_rst_d   = (w_next_state == c_S_DPA_RST);
        w_link_ok_d   = (w_next_state == c_S_LOCKED);
        w_link_fail_d = (w_next_state == c_S_FAIL);
        w_retry_d     = r_retry;
        w_win_err_d   = r_win_err;
        if (!I_enable) begin
            w_retry_d = 8'd0;
        end else if (w_fail_evt) begin
            w_retry_d = w_retry_inc;
        end
        // A window aborted by lock loss or disable leaves the last result in place
        if (I_enable && w_win_last && I_lane_dpa_done) begin
            w_win_err_d = w_err_next;
        end
    end

    // Output registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_dpa_rst   <= 1'b0;
            r_link_ok   <= 1'b0;
            r_link_fail <= 1'b0;
            r_retry     <= 8'd0;
            r_win_err   <= 16'd0;
        end else begin
            r_dpa_rst   <= w_dpa_rst_d;
            r_link_ok   <= w_link_ok_d;
            r_link_fail <= w_link_fail_d;
            r_retry     <= w_retry_d;
            r_win_err   <= w_win_err_d;
        end
    end

    // Phase counter: restarts on every state change and at each window boundary
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || w_win_last || !w_cnt_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Window error accumulator, fresh for every window
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_err <= 16'd0;
        end else if ((w_next_state != r_state) || w_win_last || !w_in_win) begin
            r_err <= 16'd0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign O_dpa_rst     = r_dpa_rst;
    assign O_link_ok     = r_link_ok;
    assign O_link_fail   = r_link_fail;
    assign O_state       = r_state;
    assign O_retry_cnt   = r_retry;
    assign O_win_err_cnt = r_win_err;

endmodule

`default_nettype wire

// File: tb/tb_lvds_dpa_link_ctrl.sv
// ============================================================================
//  Module      : tb_lvds_dpa_link_ctrl
//  Description : Scoreboard bench for lvds_dpa_link_ctrl. Stimulus queues
//                cycle-stamped expected output values; a negedge monitor
//                pops and compares them when that cycle is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lvds_dpa_link_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        done;
    logic        err;
    logic        o_dpa_rst;
    logic        o_link_ok;
    logic        o_link_fail;
    logic [2:0]  o_state;
    logic [7:0]  o_retry;
    logic [15:0] o_win_err;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];

    lvds_dpa_link_ctrl #(
        .DPA_RST_CYC (4),
        .DPA_TIMEOUT (100),
        .SETTLE_CYC  (8),
        .WIN_CYC     (32),
        .ERR_THRESH  (0),
        .MAX_RETRY   (3)
    ) dut (
        .I_clk           (clk),
        .I_rst           (rst),
        .I_enable        (enable),
        .I_lane_dpa_done (done),
        .I_error_flag    (err),
        .O_dpa_rst       (o_dpa_rst),
        .O_link_ok       (o_link_ok),
        .O_link_fail     (o_link_fail),
        .O_state         (o_state),
        .O_retry_cnt     (o_retry),
        .O_win_err_cnt   (o_win_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string nm(int sel);
        case (sel)
            0: return "state";
            1: return "dpa_rst";
            2: return "link_ok";
            3: return "link_fail";
            4: return "retry_cnt";
            default: return "win_err_cnt";
        endcase
    endfunction

    function automatic logic [15:0] act(int sel);
        case (sel)
            0: return {13'd0, o_state};
            1: return {15'd0, o_dpa_rst};
            2: return {15'd0, o_link_ok};
            3: return {15'd0, o_link_fail};
            4: return {8'd0, o_retry};
            default: return o_win_err;
        endcase
    endfunction

    // Monitor: compare every expectation stamped for the presented cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                n_cmp++;
                if (sb_q[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: check missed (now %0d)", nm(sb_q[i].sel), sb_q[i].cyc, cyc);
                end else if (act(sb_q[i].sel) !== sb_q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: got %0d expected %0d",
                             nm(sb_q[i].sel), cyc, act(sb_q[i].sel), sb_q[i].val);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic chk(input int c, input int sel, input int v);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = 16'(v);
        sb_q.push_back(e);
    endtask

    task automatic chk_all(input int c, input int st, input int drst, input int ok,
                           input int fl, input int rc, input int we);
        chk(c, 0, st);
        chk(c, 1, drst);
        chk(c, 2, ok);
        chk(c, 3, fl);
        chk(c, 4, rc);
        chk(c, 5, we);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drop enable, expect IDLE next cycle, then re-enable; n = cycle enable rises
    task automatic restart(output int n);
        int t;
        t = cyc;
        enable = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        chk(t + 1, 0, 0);
        chk(t + 1, 1, 0);
        chk(t + 1, 2, 0);
        chk(t + 1, 3, 0);
        chk(t + 1, 4, 0);
        goto(t + 1);
        enable = 1'b1;
        n = cyc;
    endtask

    task automatic pulse_err(input int c);
        goto(c);
        err = 1'b1;
        goto(c + 1);
        err = 1'b0;
    endtask

    initial begin
        int n;
        int l;
        int m;
        rst    = 1'b1;
        enable = 1'b0;
        done   = 1'b0;
        err    = 1'b0;

        // Reset state
        goto(3);
        chk_all(3, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk(4, 0, 0);

        // Clean lock
        goto(5);
        n = cyc;
        enable = 1'b1;
        chk(n + 1, 0, 1);
        chk(n + 1, 1, 1);
        chk(n + 4, 1, 1);
        chk(n + 5, 1, 0);
        chk(n + 5, 0, 2);
        chk(n + 16, 0, 3);
        chk(n + 24, 0, 4);
        chk(n + 55, 2, 0);
        chk_all(n + 56, 5, 0, 1, 0, 0, 0);
        goto(n + 15);
        done = 1'b1;

        // Error inside a LOCKED window
`ifdef LVDS_LOCKED_MONITOR_EN
        chk(n + 87, 2, 1);
        chk(n + 87, 0, 5);
        chk_all(n + 88, 1, 1, 0, 0, 1, 1);
`else
        chk_all(n + 88, 5, 0, 1, 0, 0, 0);
`endif
        pulse_err(n + 60);
        goto(n + 90);

        // Errors in first window, clean second window
        restart(n);
        goto(n + 15);
        done = 1'b1;
        pulse_err(n + 30);
        pulse_err(n + 40);
        chk_all(n + 56, 1, 1, 0, 0, 1, 2);
        goto(n + 56);
        done = 1'b0;
        chk(n + 110, 5, 2);
        chk(n + 110, 0, 4);
        chk_all(n + 111, 5, 0, 1, 0, 1, 0);
        goto(n + 70);
        done = 1'b1;

        // Loss of lock
        goto(n + 115);
        l = cyc;
        done = 1'b0;
        chk(l, 2, 1);
        chk(l + 1, 2, 0);
        chk(l + 1, 0, 1);
        chk(l + 1, 4, 1);
        chk(l + 1, 1, 1);
        goto(l + 1);
        done = 1'b1;
        goto(l + 2);

        // Timeout to fail
        restart(n);
        chk(n + 1, 0, 1);
        chk(n + 1, 1, 1);
        chk(n + 4, 1, 1);
        chk(n + 5, 1, 0);
        chk(n + 5, 0, 2);
        chk(n + 104, 0, 2);
        chk(n + 104, 4, 0);
        chk(n + 105, 0, 1);
        chk(n + 105, 4, 1);
        chk(n + 105, 1, 1);
        chk(n + 108, 1, 1);
        chk(n + 109, 1, 0);
        chk(n + 208, 0, 2);
        chk(n + 209, 0, 1);
        chk(n + 209, 4, 2);
        chk(n + 312, 0, 2);
        chk(n + 312, 3, 0);
        chk_all(n + 313, 6, 0, 0, 1, 3, 0);
        chk(n + 330, 0, 6);
        chk(n + 330, 1, 0);
        chk(n + 330, 3, 1);
        goto(n + 331);

        // Enable drop mid-window: IDLE next cycle, window result holds
        restart(n);
        goto(n + 15);
        done = 1'b1;
        pulse_err(n + 30);
        chk_all(n + 56, 1, 1, 0, 0, 1, 1);
        goto(n + 56);
        done = 1'b0;
        goto(n + 70);
        done = 1'b1;
        chk(n + 94, 0, 4);
        chk_all(n + 95, 0, 0, 0, 0, 0, 1);
        goto(n + 94);
        enable = 1'b0;
        goto(n + 95);
        done = 1'b0;

        // Reset mid-window: everything back to reset values
        m = cyc;
        enable = 1'b1;
        goto(m + 15);
        done = 1'b1;
        chk(m + 39, 0, 4);
        chk(m + 39, 5, 1);
        chk_all(m + 40, 0, 0, 0, 0, 0, 0);
        goto(m + 39);
        rst = 1'b1;
        goto(m + 40);
        rst    = 1'b0;
        enable = 1'b0;
        chk(m + 41, 0, 0);
        goto(m + 43);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad += sb_q.size();
            $display("FAIL scoreboard: %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: time limit reached at cyc %0d expected completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lvds_dpa_link_ctrl.md
Name: lvds_dpa_link_ctrl

Overview:
- Sequencer for one LVDS 7:1 receive lane pair (P/N) with dynamic phase alignment (DPA).
- Asserts DPA restart, waits for lane DPA done, then lets the lane settle.
- Qualifies the link by counting P/N mismatch error flags over a fixed window.
- Reports the link good, or retrains up to a retry limit. Sits between the LVDS RX/DPA primitive and the pattern error detector.

Parameters:
- DPA_RST_CYC, 16: cycles O_dpa_rst is held high per training attempt (min 1).
- DPA_TIMEOUT, 65535: max cycles waiting for I_lane_dpa_done before the attempt counts as failed.
- SETTLE_CYC, 64: cycles ignored after DPA done before error counting starts.
- WIN_CYC, 4096: monitor window length in cycles.
- ERR_THRESH, 0: window passes if error count <= ERR_THRESH.
- MAX_RETRY, 8: failed attempts allowed before FAIL (1..255).

Ports:
- I_clk, input, 1: system/pixel-domain clock.
- I_rst, input, 1: synchronous reset, active-high.
- I_enable, input, 1: run request; low forces IDLE.
- I_lane_dpa_done, input, 1: DPA lock status from the RX lane, level.
- I_error_flag, input, 1: per-cycle P/N data mismatch from the error detector.
- O_dpa_rst, output, 1: DPA restart to the RX lane.
- O_link_ok, output, 1: link qualified.
- O_link_fail, output, 1: retry budget exhausted.
- O_state, output, 3: current state code.
- O_retry_cnt, output, 8: failed attempts since leaving IDLE, saturating at 255.
- O_win_err_cnt, output, 16: error count of the last completed window, saturating at 0xFFFF.

Behaviour:
- Reset: state IDLE (0). O_dpa_rst=0, O_link_ok=0, O_link_fail=0, O_retry_cnt=0, O_win_err_cnt=0, all internal counters 0. Reset takes priority over everything, including mid-window.
- State codes: IDLE=0, DPA_RST=1, DPA_WAIT=2, SETTLE=3, MONITOR=4, LOCKED=5, FAIL=6.
- I_enable=0 in any state: next cycle IDLE. Clears O_link_ok, O_link_fail and O_retry_cnt. O_win_err_cnt holds.
- IDLE:
  - If I_enable=1, go to DPA_RST next cycle.
- DPA_RST:
  - O_dpa_rst=1 for exactly DPA_RST_CYC cycles (registered output, high in every cycle state==DPA_RST), then DPA_WAIT.
- DPA_WAIT:
  - O_dpa_rst=0. Timeout counter starts at 0 on entry.
  - If I_lane_dpa_done=1, go to SETTLE.
  - Else, when the counter reaches DPA_TIMEOUT-1, register an attempt failure.
  - If I_lane_dpa_done rises in the same cycle the timeout expires, done wins.
- SETTLE:
  - Wait SETTLE_CYC cycles, then MONITOR.
  - If I_lane_dpa_done drops during SETTLE, register an attempt failure.
- MONITOR:
  - Count cycles 0..WIN_CYC-1.
  - Error accumulator increments in each cycle with I_error_flag=1 and saturates at 0xFFFF.
  - If I_lane_dpa_done drops, register an attempt failure immediately; O_win_err_cnt is not updated.
  - At the last window cycle, O_win_err_cnt <= final count, including that cycle's flag.
  - Pass (count <= ERR_THRESH): LOCKED next cycle, with O_link_ok=1 in that same cycle.
  - Fail: register an attempt failure.
- Attempt failure:
  - O_retry_cnt increments (saturating).
  - If the new value >= MAX_RETRY, go to FAIL. Otherwise go to DPA_RST.
- LOCKED:
  - O_link_ok=1.
  - If I_lane_dpa_done drops: O_link_ok=0 the next cycle, O_retry_cnt unchanged, go to DPA_RST.
- FAIL:
  - O_link_fail=1, sticky until I_enable=0 or reset. No further DPA_RST pulses.
- Outputs are registered. O_link_ok and O_link_fail are never both 1.

Optional Feature:
- Macro: LVDS_LOCKED_MONITOR_EN.
- Defined: LOCKED keeps running back-to-back WIN_CYC windows. Each window updates O_win_err_cnt.
  - A window with count > ERR_THRESH: O_link_ok=0 the next cycle, O_retry_cnt increments, and the retry-limit rule applies (DPA_RST or FAIL).
- Not defined: in LOCKED, I_error_flag is ignored and O_win_err_cnt holds the value from the qualifying window.

Test Plan:
(All with DPA_RST_CYC=4, DPA_TIMEOUT=100, SETTLE_CYC=8, WIN_CYC=32, ERR_THRESH=0, MAX_RETRY=3.)
- Clean lock: I_enable=1; I_lane_dpa_done rises 10 cycles after O_dpa_rst falls; I_error_flag=0 -> O_dpa_rst high exactly 4 cycles; O_link_ok=1 after 8 settle + 32 window cycles; O_retry_cnt=0; O_win_err_cnt=0.
- Errors then pass: 2 error pulses in the first window, none in the second -> O_win_err_cnt=2, then a second O_dpa_rst pulse; after the clean window O_link_ok=1, O_retry_cnt=1, O_win_err_cnt=0.
- Timeout to fail: I_lane_dpa_done held 0 -> three 4-cycle O_dpa_rst pulses, each followed by 100 wait cycles; then O_link_fail=1, O_retry_cnt=3, O_state=6, O_dpa_rst stays 0.
- Loss of lock: in LOCKED, drop I_lane_dpa_done for 1 cycle -> O_link_ok=0 the next cycle, O_state=1, O_retry_cnt unchanged.
- Reset/enable mid-window: I_rst=1 at MONITOR cycle 15 -> next cycle every output at its reset value. Repeat with I_enable=0 -> O_state=0 next cycle, O_win_err_cnt holds.
- With LVDS_LOCKED_MONITOR_EN defined: 1 error pulse inside a LOCKED window -> O_win_err_cnt=1 at window end, O_link_ok=0 the next cycle, O_retry_cnt=1, O_state=1.
